traffic_phase_fsm: RTL
======================

// Module: traffic_phase_fsm
// PURPOSE
//  Two-road intersection phase controller: NS main road, EW side road, plus a pedestrian walk phase.
//  It consumes the free-running 2-bit yellow phase counter (0-3 wrap) and times every yellow phase
//  from it. Green, all-red and walk phases are timed with a 1-cycle tick strobe.
//  Drives the lamp outputs for both roads and the walk signal.
// PARAMETERS
//  NS_GREEN_MIN  10  minimum NS green, in ticks (1..255)
//  EW_GREEN_T    6   EW green duration, in ticks (1..255)
//  ALL_RED_T     2   all-red clearance, in ticks (1..255)
//  WALK_T        8   pedestrian walk duration, in ticks (1..255)
// PORTS
//  clk         in   1  system clock; all state on posedge
//  rst_n       in   1  asynchronous active-low reset
//  tick        in   1  1-cycle timing strobe (e.g. 1 Hz)
//  yellow_cnt  in   2  yellow counter value; asynchronous to clk, 0->1->2->3->0
//  side_car    in   1  EW vehicle sensor (level)
//  ped_req     in   1  pedestrian button (level or pulse, >=1 clk)
//  ns_light    out  3  {R,Y,G} for NS, exactly one-hot
//  ew_light    out  3  {R,Y,G} for EW, exactly one-hot
//  walk        out  1  pedestrian walk lamp
//  ped_ack     out  1  1-cycle pulse when a ped request is latched
//  phase       out  3  current state encoding (debug)
// BEHAVIOUR
//  Reset: state NS_GREEN, ns_light=001, ew_light=100, walk=0, ped_ack=0, timer=0,
//   car_pend=0, ped_pend=0, yel_steps=0, sync regs=0. Reset is honoured mid-phase, no completion.
//  yellow_cnt passes through a 2-flop synchroniser; a "step" is any change of the synced value
//   versus its previous-cycle value. Out-of-sequence jumps still count as one step.
//  States / encoding:
//   0 NS_GREEN  1 NS_YELLOW  2 RED_A  3 PED_WALK  4 EW_GREEN  5 EW_YELLOW  6 RED_B.
//  Lamps: NS_GREEN ns=G ew=R | NS_YELLOW ns=Y ew=R | EW_GREEN ns=R ew=G | EW_YELLOW ns=R ew=Y
//   | RED_A/RED_B/PED_WALK both R. walk=1 only in PED_WALK. Outputs are registered (Moore).
//  Timer: 8-bit, cleared on every state change, +1 on tick and saturating at 255.
//  Requests: car_pend is set while side_car=1 and cleared on entry to EW_GREEN.
//   ped_pend is set on ped_req=1 while ped_pend=0; ped_ack pulses the same cycle the flag sets.
//   ped_pend is cleared on entry to PED_WALK. A request arriving during its own service phase
//   re-latches for the next cycle.
//  Transitions (evaluated each clk, timer compares use value before the tick increment):
//   NS_GREEN -> NS_YELLOW  when tick && timer>=NS_GREEN_MIN-1 && (car_pend||ped_pend).
//    With no requests it holds indefinitely.
//   NS_YELLOW -> RED_A     on the 4th yellow step counted since entry (yel_steps cleared on entry).
//   RED_A -> PED_WALK if ped_pend, else -> EW_GREEN; taken when tick && timer==ALL_RED_T-1.
//   PED_WALK -> EW_GREEN if car_pend, else -> RED_B; taken when tick && timer==WALK_T-1.
//   EW_GREEN -> EW_YELLOW  when tick && timer==EW_GREEN_T-1.
//   EW_YELLOW -> RED_B     on the 4th yellow step since entry.
//   RED_B -> NS_GREEN      when tick && timer==ALL_RED_T-1.
//  Simultaneous tick and yellow step in a yellow state: the step governs and the tick is ignored.
//  Illegal state encoding: the block recovers to RED_B (all red) on the next clk.
//  Never both roads non-red in the same cycle. A yellow state always precedes an all-red state.
// TESTING
//  1 Reset with no requests, 300 ticks -> stays NS_GREEN (ns=001, ew=100); assert rst_n=0 mid-EW_GREEN
//    -> immediate ns=001, ew=100.
//  2 side_car=1 at tick 3, NS_GREEN_MIN=10 -> NS_YELLOW after 10th tick. 4 yellow_cnt steps -> RED_A.
//    2 ticks -> EW_GREEN for 6 ticks -> EW_YELLOW -> RED_B -> NS_GREEN.
//  3 ped_req pulse in NS_GREEN -> ped_ack 1 cycle. Path is NS_YELLOW, RED_A, then PED_WALK with walk=1
//    for 8 ticks, both lamps 100, then RED_B.
//  4 ped_req and side_car together -> PED_WALK then EW_GREEN. car_pend cleared, ped_pend cleared.
//  5 yellow phase: steps 3->0 wrap counted; 3 steps only -> still yellow. Tick with no step -> no
//    exit. Tick coinciding with 4th step -> exit exactly once.
//  6 Monitor across random run -> ns_light and ew_light never both !=100; phase never 7 for >1 cycle.

Source files
------------

// File: rtl/traffic_phase_fsm_if.sv
// traffic_phase_fsm_if
//   Groups the controller's sensor inputs and lamp outputs into one bundle.
//   master : the environment (sensors, tick source, yellow counter) that drives the inputs.
//   slave  : the phase controller that drives the lamps.
//   Signals:
//     tick        1  one-cycle timing strobe
//     yellow_cnt  2  free-running yellow counter, asynchronous to clk
//     side_car    1  EW vehicle sensor (level)
//     ped_req     1  pedestrian button (level or pulse)
//     ns_light    3  {R,Y,G} for NS
//     ew_light    3  {R,Y,G} for EW
//     walk        1  pedestrian walk lamp
//     ped_ack     1  one-cycle pulse when a pedestrian request is latched
//     phase       3  current state encoding (debug)
//   Handshake: there is no valid/ready pair on this bundle. Inputs are sampled
//   on every rising clk edge; tick is a qualifier that is honoured only in the
//   cycle it is high, and ped_ack is the only acknowledgement returned.
interface traffic_phase_fsm_if;
  logic       tick;
  logic [1:0] yellow_cnt;
  logic       side_car;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;

  modport master (
    output tick, yellow_cnt, side_car, ped_req,
    input  ns_light, ew_light, walk, ped_ack, phase
  );

  modport slave (
    input  tick, yellow_cnt, side_car, ped_req,
    output ns_light, ew_light, walk, ped_ack, phase
  );
endinterface

// File: rtl/traffic_phase_fsm.sv
// traffic_phase_fsm
//   Two-road intersection phase controller (NS main road, EW side road, plus a
//   pedestrian walk phase). Green, all-red and walk phases are timed in ticks;
//   yellow phases are timed by counting four steps of the external yellow counter.
//   Ports:
//     clk    in  system clock, all state on posedge
//     rst_n  in  asynchronous active-low reset
//     bus    slave modport of traffic_phase_fsm_if (sensors in, lamps out)
//   Lamp outputs are registered from the next state, so they always match phase.
module traffic_phase_fsm #(
  parameter int NS_GREEN_MIN = 10,
  parameter int EW_GREEN_T   = 6,
  parameter int ALL_RED_T    = 2,
  parameter int WALK_T       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_phase_fsm_if.slave   bus
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    RED_A     = 3'd2,
    PED_WALK  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    RED_B     = 3'd6
  } state_e;

  localparam logic [7:0] NS_MIN_M1  = 8'(NS_GREEN_MIN - 1);
  localparam logic [7:0] EW_M1      = 8'(EW_GREEN_T - 1);
  localparam logic [7:0] RED_M1     = 8'(ALL_RED_T - 1);
  localparam logic [7:0] WALK_M1    = 8'(WALK_T - 1);

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [1:0] yel_steps_q, yel_steps_d;
  logic       car_pend_q, car_pend_d;
  logic       ped_pend_q, ped_pend_d;
  logic       ped_ack_q, ped_ack_d;
  logic [1:0] ysync1_q, ysync2_q, yprev_q;
  logic [2:0] ns_q, ns_d;
  logic [2:0] ew_q, ew_d;
  logic       walk_q, walk_d;

  logic step;
  logic changed;
  logic enter_ew;
  logic enter_walk;
  logic ped_set;

  // Any change of the synchronised counter is one step, whatever the jump size.
  assign step = (ysync2_q != yprev_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NS_GREEN:  if (bus.tick && timer_q >= NS_MIN_M1 && (car_pend_q || ped_pend_q))
                   state_d = NS_YELLOW;
      // Yellow exits only on steps; a coincident tick has no effect here.
      NS_YELLOW: if (step && yel_steps_q == 2'd3) state_d = RED_A;
      RED_A:     if (bus.tick && timer_q == RED_M1)
                   state_d = ped_pend_q ? PED_WALK : EW_GREEN;
      PED_WALK:  if (bus.tick && timer_q == WALK_M1)
                   state_d = car_pend_q ? EW_GREEN : RED_B;
      EW_GREEN:  if (bus.tick && timer_q == EW_M1) state_d = EW_YELLOW;
      EW_YELLOW: if (step && yel_steps_q == 2'd3) state_d = RED_B;
      RED_B:     if (bus.tick && timer_q == RED_M1) state_d = NS_GREEN;
      // Unused encoding: fall back to all red.
      default:   state_d = RED_B;
    endcase

    changed    = (state_d != state_q);
    enter_ew   = changed && (state_d == EW_GREEN);
    enter_walk = changed && (state_d == PED_WALK);

    timer_d = timer_q;
    if (changed)                         timer_d = 8'd0;
    else if (bus.tick && timer_q != 8'hFF) timer_d = timer_q + 8'd1;

    yel_steps_d = yel_steps_q;
    if (changed) yel_steps_d = 2'd0;
    else if (step && (state_q == NS_YELLOW || state_q == EW_YELLOW))
      yel_steps_d = yel_steps_q + 2'd1;

    // Entry into the service phase clears the flag; a still-present request
    // re-latches on the following cycle.
    car_pend_d = car_pend_q;
    if (enter_ew)          car_pend_d = 1'b0;
    else if (bus.side_car) car_pend_d = 1'b1;

    ped_set    = bus.ped_req && !ped_pend_q && !enter_walk;
    ped_pend_d = ped_pend_q;
    if (enter_walk)   ped_pend_d = 1'b0;
    else if (ped_set) ped_pend_d = 1'b1;
    ped_ack_d = ped_set;

    ns_d   = LAMP_R;
    ew_d   = LAMP_R;
    walk_d = 1'b0;
    unique case (state_d)
      NS_GREEN:  ns_d = LAMP_G;
      NS_YELLOW: ns_d = LAMP_Y;
      EW_GREEN:  ew_d = LAMP_G;
      EW_YELLOW: ew_d = LAMP_Y;
      PED_WALK:  walk_d = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= NS_GREEN;
      timer_q     <= 8'd0;
      yel_steps_q <= 2'd0;
      car_pend_q  <= 1'b0;
      ped_pend_q  <= 1'b0;
      ped_ack_q   <= 1'b0;
      ysync1_q    <= 2'd0;
      ysync2_q    <= 2'd0;
      yprev_q     <= 2'd0;
      ns_q        <= LAMP_G;
      ew_q        <= LAMP_R;
      walk_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      yel_steps_q <= yel_steps_d;
      car_pend_q  <= car_pend_d;
      ped_pend_q  <= ped_pend_d;
      ped_ack_q   <= ped_ack_d;
      ysync1_q    <= bus.yellow_cnt;
      ysync2_q    <= ysync1_q;
      yprev_q     <= ysync2_q;
      ns_q        <= ns_d;
      ew_q        <= ew_d;
      walk_q      <= walk_d;
    end
  end

  assign bus.ns_light = ns_q;
  assign bus.ew_light = ew_q;
  assign bus.walk     = walk_q;
  assign bus.ped_ack  = ped_ack_q;
  assign bus.phase    = state_q;

endmodule
